led_chaser: RTL

Parametrised LED running-light generator, the next generation of the board's fixed 4-LED water light. It drives N_LED indicators from an internal step prescaler, supports four display modes (rotate right, rotate left, bounce, fill bar), an enable/pause input and selectable output polarity. It sits at board top level, directly driving LED pins, with en and mode tied to switches or a control register.

---
 rtl/led_chaser.sv | 105 ++++++++++
 1 files changed

// File: rtl/led_chaser.sv
// Running-light generator: a prescaler produces a step tick, and a small
// OFF/RUN FSM advances an N_LED lit-pattern in one of four display modes.
module led_chaser #(
  parameter int N_LED      = 4,
  parameter int DIV        = 50_000_000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [N_LED-1:0] led,
  output logic             step
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  localparam logic [0:0] ST_OFF   = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [0:0] DIR_DOWN = 1'b0;
  localparam logic [0:0] DIR_UP   = 1'b1;

  localparam logic [N_LED-1:0] P_TOP = {1'b1, {(N_LED-1){1'b0}}};
  localparam logic [N_LED-1:0] P_ONE = {{(N_LED-1){1'b0}}, 1'b1};

  logic [N_LED-1:0] p_q, p_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [0:0]       st_q, st_d;
  logic [0:0]       dir_q, dir_d;
  logic [1:0]       mode_q, mode_d;
  logic             step_q;
  logic             tick;
  logic [N_LED-1:0] start_p;
  logic [N_LED-1:0] shr, shl;

  assign tick    = en && (cnt_q == CNT_MAX);
  assign start_p = (mode == 2'd1) ? P_ONE : P_TOP;
  assign shr     = p_q >> 1;
  assign shl     = p_q << 1;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_comb begin
    p_d    = p_q;
    st_d   = st_q;
    dir_d  = dir_q;
    mode_d = mode_q;
    if (tick) begin
      // A mode change restarts from the start pattern instead of advancing.
      if (st_q == ST_OFF || mode != mode_q) begin
        p_d    = start_p;
        mode_d = mode;
        dir_d  = DIR_DOWN;
        st_d   = ST_RUN;
      end else begin
        unique case (mode_q)
          2'd0: p_d = {p_q[0], p_q[N_LED-1:1]};
          2'd1: p_d = {p_q[N_LED-2:0], p_q[N_LED-1]};
          2'd2: begin
            if (dir_q == DIR_DOWN) begin
              p_d = shr;
              if (shr[0]) dir_d = DIR_UP;
            end else begin
              p_d = shl;
              if (shl[N_LED-1]) dir_d = DIR_DOWN;
            end
          end
          default: begin
            if (&p_q)           p_d = '0;
            else if (p_q == '0) p_d = P_TOP;
            else                p_d = {1'b1, p_q[N_LED-1:1]};
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q    <= '0;
      cnt_q  <= '0;
      st_q   <= ST_OFF;
      dir_q  <= DIR_DOWN;
      mode_q <= 2'd0;
      step_q <= 1'b0;
    end else begin
      p_q    <= p_d;
      cnt_q  <= cnt_d;
      st_q   <= st_d;
      dir_q  <= dir_d;
      mode_q <= mode_d;
      step_q <= tick;
    end
  end

  assign led  = ACTIVE_LOW ? ~p_q : p_q;
  assign step = step_q;

endmodule
